box_overlay: RTL and testbench
==============================

// Module: box_overlay
// PURPOSE
//   Downstream of the location tracker. Consumes the raster RGB pixel stream from an input FIFO read port.
//   Latches the tracker's bounding box (center/width/height).
//   Draws a solid-colour rectangle outline of that box onto the next frame and writes pixels to an output FIFO.
//   Frames with no reported box pass through unmodified.
// PARAMETERS
//   WIDTH      640        pixels per line
//   HEIGHT     480        lines per frame
//   THICK      2          outline thickness in pixels (>=1)
//   BOX_COLOR  24'hFF0000 RGB written on outline pixels ({R,G,B})
// PORTS
//   clock       in   1   single clock; all logic on posedge
//   reset       in   1   synchronous, active-high
//   in_empty    in   1   input FIFO empty
//   in_dout     in   24  input FIFO data {R[23:16],G[15:8],B[7:0]}
//   in_rd_en    out  1   input FIFO pop (combinational, qualified by ~in_empty)
//   out_full    in   1   output FIFO full
//   out_wr_en   out  1   output FIFO push (combinational, qualified by ~out_full)
//   out_din     out  24  output pixel
//   box_valid   in   1   1-cycle pulse from tracker: box fields valid
//   center_x    in   12  box center column
//   center_y    in   12  box center row
//   width       in   12  box width in pixels (0 = no box)
//   height      in   12  box height in pixels (0 = no box)
//   box_active  out  1   registered; 1 while current frame is drawn with a box
//   frame_done  out  1   registered 1-cycle pulse after last pixel of a frame is pushed
// BEHAVIOUR
//   Reset: state=S_LOAD, x=y=0, pending flag/box=0, active box disabled, pixel reg=0; box_active=0, frame_done=0.
//     in_rd_en/out_wr_en are 0 during reset. out_din follows pixel reg/overlay (0 in reset).
//   Reset mid-frame: discard partial frame and restart at (0,0). FIFOs are not flushed by this block.
//   Pending box: on box_valid, store fields and set pend=1. A later pulse overwrites (last wins).
//   FSM states:
//     S_LOAD (1 cycle): activate the pending box if pend=1 and width!=0 and height!=0; else disable.
//       Clear pend; box_active<=enable; ->S_READ.
//       A box_valid in this same cycle is stored as pending for the NEXT frame.
//     S_READ: if ~in_empty: in_rd_en=1, pix<=in_dout, ->S_WRITE; else hold.
//     S_WRITE: if ~out_full: out_wr_en=1, out_din=border?BOX_COLOR:pix; advance x.
//       At x==WIDTH-1: x=0, y++. Last pixel (WIDTH-1,HEIGHT-1): x=y=0, frame_done<=1, ->S_LOAD.
//       Otherwise ->S_READ. If out_full: hold state and pixel.
//   Throughput: 1 pixel per 2 cycles, plus 1 S_LOAD cycle per frame. Back-pressure never drops or duplicates pixels.
//   Bounds (12-bit, computed in S_LOAD, 13-bit intermediates):
//     hx=(width-1)>>1; left = center_x>=hx ? center_x-hx : 0; right = min(left+width-1, WIDTH-1).
//     Vertical: same rule with height, center_y, HEIGHT -> top, bottom.
//     This exactly inverts the tracker's center=(a+b)>>1, size=b-a+1.
//   border = enable & left<=x<=right & top<=y<=bottom &
//     ((x-left)<THICK | (right-x)<THICK | (y-top)<THICK | (bottom-y)<THICK). Differences never underflow.
//   The box is never applied mid-frame; a box received during frame N draws on frame N+1.
// TESTING (bench WIDTH=8 HEIGHT=6 THICK=1)
//   No box_valid; input ramp pixels 0..47 -> output identical in order; box_active=0; frame_done once per frame.
//   box_valid cx=4 cy=3 w=5 h=3 mid-frame 0 -> frame 0 unchanged; frame 1: x2..6 at rows 2,4 and cols 2,6 rows 2..4 = FF0000; (3..5,3) unchanged.
//   cx=1 w=7 -> left=0,right=6; cx=7 w=5 -> left=5,right=7 (clamped). w=0 -> frame passes unmodified, box_active=0.
//   Random in_empty gaps + out_full high 10 cycles mid-frame -> exactly 48 pushes per frame, order preserved, no rd_en while in S_WRITE.
//   Two box_valid pulses in a frame -> second box drawn. Pulse in the S_LOAD cycle -> applies to the following frame.
//   Assert reset at pixel 20 -> next cycle box_active=0, frame_done=0; next push is pixel (0,0) of the new input.

Source files
------------

// File: rtl/box_overlay_if.sv
// Pixel FIFO ports and tracker box fields shared between box_overlay and its surroundings.
interface box_overlay_if;
    localparam int unsigned PIX_W = 24;
    localparam int unsigned CRD_W = 12;

    logic              in_empty;
    logic [PIX_W-1:0]  in_dout;
    logic              in_rd_en;
    logic              out_full;
    logic              out_wr_en;
    logic [PIX_W-1:0]  out_din;
    logic              box_valid;
    logic [CRD_W-1:0]  center_x;
    logic [CRD_W-1:0]  center_y;
    logic [CRD_W-1:0]  width;
    logic [CRD_W-1:0]  height;
    logic              box_active;
    logic              frame_done;

    modport master (
        output in_empty, in_dout, out_full,
        output box_valid, center_x, center_y, width, height,
        input  in_rd_en, out_wr_en, out_din, box_active, frame_done
    );

    modport slave (
        input  in_empty, in_dout, out_full,
        input  box_valid, center_x, center_y, width, height,
        output in_rd_en, out_wr_en, out_din, box_active, frame_done
    );
endinterface

// File: rtl/box_overlay.sv
// Copies a raster RGB stream FIFO-to-FIFO, drawing the tracker's last reported box
// outline onto the frame that follows the report.
module box_overlay #(
    parameter int unsigned WIDTH     = 640,
    parameter int unsigned HEIGHT    = 480,
    parameter int unsigned THICK     = 2,
    parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
    input  logic         clock,
    input  logic         reset,
    box_overlay_if.slave bus
);
    localparam int unsigned PIX_W = 24;
    localparam int unsigned CRD_W = 12;
    localparam int unsigned EXT_W = CRD_W + 1;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CRD_W-1:0]   x_q, x_d, y_q, y_d;
    logic               pend_q, pend_d;
    logic [CRD_W-1:0]   pcx_q, pcx_d, pcy_q, pcy_d, pw_q, pw_d, ph_q, ph_d;
    logic               en_q, en_d;
    logic [CRD_W-1:0]   left_q, left_d, right_q, right_d, top_q, top_d, bot_q, bot_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic               box_active_q, box_active_d;
    logic               frame_done_q, frame_done_d;
    logic               rd_en_c, wr_en_c, border_c;

    // Bounds of the pending box; 13-bit so width-1 and left+width-1 cannot wrap
    logic [EXT_W-1:0]   hx_w, hx_h, rsum, bsum;
    logic [CRD_W-1:0]   left_c, right_c, top_c, bot_c;

    always_comb begin
        hx_w    = (EXT_W'(pw_q) - EXT_W'(1)) >> 1;
        hx_h    = (EXT_W'(ph_q) - EXT_W'(1)) >> 1;
        left_c  = (EXT_W'(pcx_q) >= hx_w) ? CRD_W'(EXT_W'(pcx_q) - hx_w) : '0;
        top_c   = (EXT_W'(pcy_q) >= hx_h) ? CRD_W'(EXT_W'(pcy_q) - hx_h) : '0;
        rsum    = EXT_W'(left_c) + EXT_W'(pw_q) - EXT_W'(1);
        bsum    = EXT_W'(top_c) + EXT_W'(ph_q) - EXT_W'(1);
        right_c = (rsum > EXT_W'(WIDTH - 1))  ? CRD_W'(WIDTH - 1)  : CRD_W'(rsum);
        bot_c   = (bsum > EXT_W'(HEIGHT - 1)) ? CRD_W'(HEIGHT - 1) : CRD_W'(bsum);
    end

    // Outline hit test; range checks come first so the differences stay non-negative
    always_comb begin
        border_c = en_q
                 && (x_q >= left_q) && (x_q <= right_q)
                 && (y_q >= top_q)  && (y_q <= bot_q)
                 && (((x_q - left_q)  < CRD_W'(THICK)) ||
                     ((right_q - x_q) < CRD_W'(THICK)) ||
                     ((y_q - top_q)   < CRD_W'(THICK)) ||
                     ((bot_q - y_q)   < CRD_W'(THICK)));
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        pend_d       = pend_q;
        pcx_d        = pcx_q;
        pcy_d        = pcy_q;
        pw_d         = pw_q;
        ph_d         = ph_q;
        en_d         = en_q;
        left_d       = left_q;
        right_d      = right_q;
        top_d        = top_q;
        bot_d        = bot_q;
        pix_d        = pix_q;
        box_active_d = box_active_q;
        frame_done_d = 1'b0;
        rd_en_c      = 1'b0;
        wr_en_c      = 1'b0;

        if (bus.box_valid) begin
            pend_d = 1'b1;
            pcx_d  = bus.center_x;
            pcy_d  = bus.center_y;
            pw_d   = bus.width;
            ph_d   = bus.height;
        end

        unique case (state_q)
            S_LOAD: begin
                en_d         = pend_q && (pw_q != '0) && (ph_q != '0);
                left_d       = left_c;
                right_d      = right_c;
                top_d        = top_c;
                bot_d        = bot_c;
                box_active_d = en_d;
                // A report arriving now belongs to the next frame
                if (!bus.box_valid) begin
                    pend_d = 1'b0;
                end
                state_d = S_READ;
            end
            S_READ: begin
                if (!bus.in_empty) begin
                    rd_en_c = 1'b1;
                    pix_d   = bus.in_dout;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!bus.out_full) begin
                    wr_en_c = 1'b1;
                    state_d = S_READ;
                    if (x_q == CRD_W'(WIDTH - 1)) begin
                        x_d = '0;
                        if (y_q == CRD_W'(HEIGHT - 1)) begin
                            y_d          = '0;
                            frame_done_d = 1'b1;
                            state_d      = S_LOAD;
                        end else begin
                            y_d = y_q + CRD_W'(1);
                        end
                    end else begin
                        x_d = x_q + CRD_W'(1);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_LOAD;
            x_q          <= '0;
            y_q          <= '0;
            pend_q       <= 1'b0;
            pcx_q        <= '0;
            pcy_q        <= '0;
            pw_q         <= '0;
            ph_q         <= '0;
            en_q         <= 1'b0;
            left_q       <= '0;
            right_q      <= '0;
            top_q        <= '0;
            bot_q        <= '0;
            pix_q        <= '0;
            box_active_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pend_q       <= pend_d;
            pcx_q        <= pcx_d;
            pcy_q        <= pcy_d;
            pw_q         <= pw_d;
            ph_q         <= ph_d;
            en_q         <= en_d;
            left_q       <= left_d;
            right_q      <= right_d;
            top_q        <= top_d;
            bot_q        <= bot_d;
            pix_q        <= pix_d;
            box_active_q <= box_active_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.in_rd_en   = rd_en_c & ~reset;
    assign bus.out_wr_en  = wr_en_c & ~reset;
    assign bus.out_din    = reset ? '0 : (border_c ? BOX_COLOR : pix_q);
    assign bus.box_active = box_active_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_box_overlay.sv
// Directed bench for box_overlay on an 8x6 frame with a 1-pixel outline.
module tb_box_overlay;
    localparam int unsigned W = 8;
    localparam int unsigned H = 6;
    localparam int unsigned N = W * H;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    box_overlay_if bus();

    box_overlay #(
        .WIDTH    (W),
        .HEIGHT   (H),
        .THICK    (1),
        .BOX_COLOR(24'hFF0000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int          n_tests  = 0;
    int          n_fail   = 0;
    logic [23:0] in_q[$];
    logic [23:0] out_q[$];
    int          fd_size[$];
    bit          gap_en   = 1'b0;
    int          full_cnt = 0;
    int          overlap  = 0;
    logic        mon_rd, mon_wr;
    logic [23:0] mon_val;

    // Hand-derived box per frame: enable, left, right, top, bottom
    int f_en[8] = '{0, 1, 1, 1, 0, 1, 0, 1};
    int f_l[8]  = '{0, 2, 0, 5, 0, 2, 0, 2};
    int f_r[8]  = '{0, 6, 6, 7, 0, 4, 0, 6};
    int f_t[8]  = '{0, 2, 2, 2, 0, 1, 0, 2};
    int f_b[8]  = '{0, 4, 4, 4, 0, 3, 0, 4};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] expv(input int base, input int i, input int en,
                                         input int l, input int r, input int t, input int b);
        int x;
        int y;
        bit bd;
        x  = i % W;
        y  = i / W;
        bd = (en != 0) && x >= l && x <= r && y >= t && y <= b &&
             (x == l || x == r || y == t || y == b);
        return bd ? 24'hFF0000 : 24'(base + i);
    endfunction

    // FIFO models: sample handshakes mid-cycle, commit them just after the edge
    initial begin
        bus.in_empty = 1'b1;
        bus.in_dout  = '0;
        bus.out_full = 1'b0;
        forever begin
            @(negedge clock);
            mon_rd  = bus.in_rd_en;
            mon_wr  = bus.out_wr_en;
            mon_val = bus.out_din;
            if (bus.frame_done) fd_size.push_back(out_q.size());
            @(posedge clock);
            #1;
            if (mon_rd && in_q.size() > 0) void'(in_q.pop_front());
            if (mon_wr) out_q.push_back(mon_val);
            if (mon_rd && mon_wr) overlap++;
            if (full_cnt > 0) full_cnt--;
            bus.out_full = (full_cnt > 0);
            bus.in_empty = (in_q.size() == 0) || (gap_en && $urandom_range(0, 2) == 0);
            bus.in_dout  = (in_q.size() > 0) ? in_q[0] : 24'h0;
        end
    end

    task automatic wait_out(input int n, input string tag);
        int k;
        k = 0;
        while (out_q.size() < n && k < 4000) begin
            @(posedge clock);
            k++;
        end
        #2;
        check({tag, "_reached"}, 32'(out_q.size() >= n), 32'd1);
    endtask

    task automatic pulse_box(input logic [11:0] cx, input logic [11:0] cy,
                             input logic [11:0] w, input logic [11:0] h);
        @(posedge clock);
        #2;
        bus.box_valid = 1'b1;
        bus.center_x  = cx;
        bus.center_y  = cy;
        bus.width     = w;
        bus.height    = h;
        @(posedge clock);
        #2;
        bus.box_valid = 1'b0;
    endtask

    initial begin
        int n_at;
        int n0;
        int k;
        bus.box_valid = 1'b0;
        bus.center_x  = '0;
        bus.center_y  = '0;
        bus.width     = '0;
        bus.height    = '0;
        for (int f = 0; f < 9; f++)
            for (int i = 0; i < N; i++) in_q.push_back(24'(f * 100 + i));

        repeat (3) @(posedge clock);
        #2;
        check("rst_box_active", 32'(bus.box_active), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_rd_en",      32'(bus.in_rd_en),   32'd0);
        check("rst_wr_en",      32'(bus.out_wr_en),  32'd0);
        check("rst_out_din",    32'(bus.out_din),    32'd0);
        reset = 1'b0;

        wait_out(20, "f0");
        check("f0_active", 32'(bus.box_active), 32'd0);
        pulse_box(12'd4, 12'd3, 12'd5, 12'd3);
        wait_out(N + 20, "f1");
        check("f1_active", 32'(bus.box_active), 32'd1);
        pulse_box(12'd1, 12'd3, 12'd7, 12'd3);
        wait_out(2 * N + 20, "f2");
        check("f2_active", 32'(bus.box_active), 32'd1);
        pulse_box(12'd7, 12'd3, 12'd5, 12'd3);
        wait_out(3 * N + 20, "f3");
        check("f3_active", 32'(bus.box_active), 32'd1);
        pulse_box(12'd4, 12'd3, 12'd0, 12'd3);

        wait_out(4 * N + 5, "f4");
        check("f4_active", 32'(bus.box_active), 32'd0);
        gap_en = 1'b1;
        pulse_box(12'd4, 12'd3, 12'd5, 12'd3);
        wait_out(4 * N + 15, "f4b");
        pulse_box(12'd3, 12'd2, 12'd3, 12'd3);
        wait_out(4 * N + 25, "f4c");
        full_cnt = 11;

        wait_out(5 * N + 20, "f5");
        check("f5_active", 32'(bus.box_active), 32'd1);
        wait_out(5 * N + 40, "f5_end");
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!bus.frame_done && k < 400);
        check("load_seen", 32'(bus.frame_done), 32'd1);
        bus.box_valid = 1'b1;
        bus.center_x  = 12'd4;
        bus.center_y  = 12'd3;
        bus.width     = 12'd5;
        bus.height    = 12'd3;
        @(posedge clock);
        #2;
        bus.box_valid = 1'b0;

        wait_out(6 * N + 20, "f6");
        check("f6_active", 32'(bus.box_active), 32'd0);
        wait_out(7 * N + 20, "f7");
        check("f7_active", 32'(bus.box_active), 32'd1);

        wait_out(8 * N + 20, "f8");
        reset = 1'b1;
        in_q.delete();
        n_at = out_q.size();
        @(posedge clock);
        #2;
        check("rs_box_active", 32'(bus.box_active), 32'd0);
        check("rs_frame_done", 32'(bus.frame_done), 32'd0);
        check("rs_rd_en",      32'(bus.in_rd_en),   32'd0);
        reset = 1'b0;
        n0 = out_q.size();
        check("rs_no_push", 32'(n0), 32'(n_at));
        for (int i = 0; i < N; i++) in_q.push_back(24'(900 + i));
        wait_out(n0 + N, "f9");

        for (int f = 0; f < 8; f++)
            for (int i = 0; i < N; i++)
                check($sformatf("f%0d_px%0d", f, i), 32'(out_q[f * N + i]),
                      32'(expv(f * 100, i, f_en[f], f_l[f], f_r[f], f_t[f], f_b[f])));
        for (int i = 0; i < 20; i++)
            check($sformatf("f8_px%0d", i), 32'(out_q[8 * N + i]), 32'(800 + i));
        for (int i = 0; i < N; i++)
            check($sformatf("f9_px%0d", i), 32'(out_q[n0 + i]), 32'(900 + i));

        check("fd_count", 32'(fd_size.size() >= 8), 32'd1);
        for (int j = 0; j < 8 && j < fd_size.size(); j++)
            check($sformatf("fd_size%0d", j), 32'(fd_size[j]), 32'((j + 1) * N));
        check("rd_during_wr", 32'(overlap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
